// File: rtl/delayw_mc.sv
// delayw_mc: multi-channel programmable sample delay with per-channel history-valid flags
module delayw_mc #(
    parameter int LGDLY = 4,
    parameter int DW = 12,
    parameter int NCH = 2,
    parameter logic [LGDLY-1:0] INIT_DELAY = '0,
    localparam int LGNCH = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_cfg_wr,
    input  logic [LGNCH-1:0]   i_cfg_chan,
    input  logic [LGDLY-1:0]   i_cfg_delay,
    input  logic               i_ce,
    input  logic [NCH*DW-1:0]  i_word,
    output logic               o_ce,
    output logic [NCH*DW-1:0]  o_word,
    output logic [NCH*DW-1:0]  o_delayed,
    output logic [NCH-1:0]     o_valid
);
    logic [LGDLY-1:0] wptr;
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_ce <= 1'b0;
            o_word <= '0;
            wptr <= '0;
        end else begin
            o_ce <= i_ce;
            if (i_ce) begin
                o_word <= i_word;
                wptr <= wptr + 1'b1;
            end
        end
    end
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW-1:0] mem [0:(1<<LGDLY)-1];
        logic [DW-1:0] din, rd, del;
        logic [LGDLY-1:0] dly, d_eff;
        logic [LGDLY:0] cnt, c_eff, c_nxt;
        logic hit, vld, ok;
        assign din = i_word[c*DW +: DW];
        always_comb begin
            hit = i_cfg_wr && (i_cfg_chan == LGNCH'(c));
            d_eff = hit ? i_cfg_delay : dly;
            c_eff = hit ? '0 : cnt;
            c_nxt = (c_eff > {1'b0, d_eff}) ? c_eff : c_eff + 1'b1;
            ok = c_nxt > {1'b0, d_eff};
            rd = (d_eff == '0) ? din : mem[wptr - d_eff];
        end
        always_ff @(posedge i_clk) begin
            if (i_ce)
                mem[wptr] <= din;
        end
        always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
                dly <= INIT_DELAY;
                cnt <= '0;
                vld <= 1'b0;
                del <= '0;
            end else begin
                if (hit)
                    dly <= i_cfg_delay;
                if (i_ce) begin
                    cnt <= c_nxt;
                    vld <= ok;
                    del <= ok ? rd : '0;
                end else if (hit)
                    cnt <= '0;
            end
        end
        assign o_valid[c] = vld;
        assign o_delayed[c*DW +: DW] = del;
    end
endmodule

// File: tb/tb_delayw_mc.sv
// tb_delayw_mc: randomized and directed checks of delayw_mc against a sample-history model
module tb_delayw_mc;
    localparam int LGDLY = 4;
    localparam int DW = 12;
    localparam int NCH = 3;
    localparam int LGNCH = 2;
    localparam int INIT = 2;
    localparam int W = NCH * DW;

    logic clk = 1'b0;
    logic rst_n, cfg_wr, ce;
    logic [LGNCH-1:0] cfg_chan;
    logic [LGDLY-1:0] cfg_delay;
    logic [W-1:0] word;
    logic o_ce;
    logic [W-1:0] o_word, o_delayed;
    logic [NCH-1:0] o_valid;

    logic e_ce;
    logic [W-1:0] e_word, e_del;
    logic [NCH-1:0] e_val;
    logic [W-1:0] hist [$];
    int md [NCH];
    int ms [NCH];
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    delayw_mc #(.LGDLY(LGDLY), .DW(DW), .NCH(NCH), .INIT_DELAY(LGDLY'(INIT))) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_cfg_wr(cfg_wr), .i_cfg_chan(cfg_chan),
        .i_cfg_delay(cfg_delay), .i_ce(ce), .i_word(word), .o_ce(o_ce),
        .o_word(o_word), .o_delayed(o_delayed), .o_valid(o_valid)
    );

    function automatic logic [W-1:0] ramp(input int x);
        logic [W-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*DW +: DW] = DW'(x + 100 * c);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // x[n] delayed by d is valid once d samples have arrived since the channel's last reset/config
    task automatic tick(input bit rs, input bit c_e, input logic [W-1:0] w, input bit wr, input int ch, input int dl);
        logic [W-1:0] h;
        int n;
        rst_n = !rs;
        ce = c_e;
        word = w;
        cfg_wr = wr;
        cfg_chan = ch[LGNCH-1:0];
        cfg_delay = dl[LGDLY-1:0];
        @(posedge clk);
        if (rs) begin
            hist.delete();
            for (int c = 0; c < NCH; c++) begin
                md[c] = INIT;
                ms[c] = 0;
            end
            e_ce = 1'b0;
            e_word = '0;
            e_del = '0;
            e_val = '0;
        end else begin
            if (wr && ch < NCH) begin
                md[ch] = dl;
                ms[ch] = hist.size();
            end
            e_ce = c_e;
            if (c_e) begin
                hist.push_back(w);
                n = hist.size() - 1;
                e_word = w;
                for (int c = 0; c < NCH; c++) begin
                    if (n - ms[c] >= md[c]) begin
                        h = hist[n - md[c]];
                        e_del[c*DW +: DW] = h[c*DW +: DW];
                        e_val[c] = 1'b1;
                    end else begin
                        e_del[c*DW +: DW] = '0;
                        e_val[c] = 1'b0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, ramp(7), 1, 0, 5);
        tick(1, 1, ramp(8), 1, 1, 5);
        checks++;
        if ({o_ce, o_word, o_delayed, o_valid} !== '0) begin
            fails++;
            $display("FAIL reset got %b/%h/%h/%b exp all zero", o_ce, o_word, o_delayed, o_valid);
        end
    endtask

    task automatic test_ramp();
        tick(0, 0, '0, 1, 0, 3);
        tick(0, 0, '0, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, ramp(i + 1), 0, 0, 0);
            checks++;
            if ({o_ce, o_word, o_delayed, o_valid} !== {e_ce, e_word, e_del, e_val}) begin
                fails++;
                $display("FAIL ramp i=%0d got %b/%h/%h/%b exp %b/%h/%h/%b", i, o_ce, o_word, o_delayed, o_valid, e_ce, e_word, e_del, e_val);
            end
            checks++;
            if (o_valid[0] !== (i >= 3) || o_delayed[DW-1:0] !== ((i >= 3) ? DW'(i - 2) : '0)) begin
                fails++;
                $display("FAIL ramp_ch0 i=%0d got v=%b d=%h exp v=%b d=%h", i, o_valid[0], o_delayed[DW-1:0], i >= 3, (i >= 3) ? i - 2 : 0);
            end
        end
    endtask

    task automatic test_sparse();
        tick(1, 0, '0, 0, 0, 0);
        tick(0, 0, '0, 1, 0, 3);
        tick(0, 0, '0, 1, 1, 0);
        for (int i = 0; i < 24; i++) begin
            tick(0, i % 3 == 0, ramp(i / 3 + 1), 0, 0, 0);
            checks++;
            if ({o_ce, o_word, o_delayed, o_valid} !== {e_ce, e_word, e_del, e_val}) begin
                fails++;
                $display("FAIL sparse i=%0d got %b/%h/%h/%b exp %b/%h/%h/%b", i, o_ce, o_word, o_delayed, o_valid, e_ce, e_word, e_del, e_val);
            end
        end
    endtask

    task automatic test_wrap();
        tick(1, 0, '0, 0, 0, 0);
        tick(0, 0, '0, 1, 0, 15);
        for (int i = 0; i < 40; i++) begin
            tick(0, 1, ramp(i + 1), 0, 0, 0);
            checks++;
            if ({o_ce, o_word, o_delayed, o_valid} !== {e_ce, e_word, e_del, e_val}) begin
                fails++;
                $display("FAIL wrap i=%0d got %b/%h/%h/%b exp %b/%h/%h/%b", i, o_ce, o_word, o_delayed, o_valid, e_ce, e_word, e_del, e_val);
            end
            checks++;
            if (o_valid[0] !== (i >= 15) || o_delayed[DW-1:0] !== ((i >= 15) ? DW'(i - 14) : '0)) begin
                fails++;
                $display("FAIL wrap_ch0 i=%0d got v=%b d=%h", i, o_valid[0], o_delayed[DW-1:0]);
            end
        end
    endtask

    task automatic test_midwrite();
        tick(1, 0, '0, 0, 0, 0);
        tick(0, 0, '0, 1, 0, 3);
        tick(0, 0, '0, 1, 1, 0);
        for (int i = 0; i < 10; i++) tick(0, 1, ramp(i + 1), 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            tick(0, 1, ramp(k + 11), k == 0, 0, 5);
            checks++;
            if ({o_ce, o_word, o_delayed, o_valid} !== {e_ce, e_word, e_del, e_val}) begin
                fails++;
                $display("FAIL midwrite k=%0d got %b/%h/%h/%b exp %b/%h/%h/%b", k, o_ce, o_word, o_delayed, o_valid, e_ce, e_word, e_del, e_val);
            end
            checks++;
            if (o_valid[1:0] !== {1'b1, k >= 5} || o_delayed[DW-1:0] !== ((k >= 5) ? DW'(k + 6) : '0)) begin
                fails++;
                $display("FAIL midwrite_flags k=%0d got v=%b d0=%h", k, o_valid, o_delayed[DW-1:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(0, 0, '0, 1, 0, 1);
        for (int i = 0; i < 6; i++) tick(0, 1, rnd(), 0, 0, 0);
        tick(1, 1, rnd(), 1, 2, 9);
        checks++;
        if ({o_ce, o_word, o_delayed, o_valid} !== '0) begin
            fails++;
            $display("FAIL reset_mid got %b/%h/%h/%b exp all zero", o_ce, o_word, o_delayed, o_valid);
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, rnd(), 0, 0, 0);
            checks++;
            if ({o_ce, o_word, o_delayed, o_valid} !== {e_ce, e_word, e_del, e_val}) begin
                fails++;
                $display("FAIL refill i=%0d got %b/%h/%h/%b exp %b/%h/%h/%b", i, o_ce, o_word, o_delayed, o_valid, e_ce, e_word, e_del, e_val);
            end
            checks++;
            if (o_valid !== ((i >= INIT) ? 3'b111 : 3'b000)) begin
                fails++;
                $display("FAIL refill_valid i=%0d got %b", i, o_valid);
            end
        end
    endtask

    task automatic test_bad_chan();
        tick(1, 0, '0, 0, 0, 0);
        tick(0, 0, '0, 1, 0, 4);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, rnd(), i == 2 || i == 4, 3, 0);
            if (i == 5) tick(0, 0, '0, 1, 3, 1);
            checks++;
            if ({o_ce, o_word, o_delayed, o_valid} !== {e_ce, e_word, e_del, e_val}) begin
                fails++;
                $display("FAIL bad_chan i=%0d got %b/%h/%h/%b exp %b/%h/%h/%b", i, o_ce, o_word, o_delayed, o_valid, e_ce, e_word, e_del, e_val);
            end
            checks++;
            if (o_valid !== {(i >= 2) ? 2'b11 : 2'b00, i >= 4}) begin
                fails++;
                $display("FAIL bad_chan_valid i=%0d got %b", i, o_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, rnd(),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 3), $urandom_range(0, 15));
            checks++;
            if ({o_ce, o_word, o_delayed, o_valid} !== {e_ce, e_word, e_del, e_val}) begin
                fails++;
                $display("FAIL random i=%0d got %b/%h/%h/%b exp %b/%h/%h/%b", i, o_ce, o_word, o_delayed, o_valid, e_ce, e_word, e_del, e_val);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ce = 1'b0;
        cfg_wr = 1'b0;
        cfg_chan = '0;
        cfg_delay = '0;
        word = '0;
        test_reset();
        test_ramp();
        test_sparse();
        test_wrap();
        test_midwrite();
        test_reset_mid();
        test_bad_chan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
